regfile_arbiter: RTL

Round-robin access controller that shares the single read port and single write port of the team's `regfile` storage block among `NREQ` requesters in the NoC. Each cycle it grants at most one read and one write independently, routes the one-cycle-late read data back to the winning requester, and provides a hardware clear sequence that zeroes every entry without a global reset. It sits between the NoC node logic and one `regfile` instance and drives all of that instance's control and data ports.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/rr_arbiter.sv | 47 ++++
 rtl/regfile_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared defaults and clear-FSM encoding for regfile_arbiter.
// Imported by rr_arbiter and regfile_arbiter.
package regfile_pkg;

   localparam int RF_NREQ     = 4;
   localparam int RF_WIDTH    = 16;
   localparam int RF_DEPTH    = 32;
   localparam int RF_ADDWIDTH = 5;

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_CLEAR = 1'b1;

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: rotating-priority grant with a registered pointer.
// Ports: clk, reset (async low), req, freeze (blocks grants, holds ptr), gnt.
module rr_arbiter
   import regfile_pkg::*;
#(
   parameter int N = RF_NREQ
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] req,
   input  logic         freeze,
   output logic [N-1:0] gnt
);

   localparam int PW = (N > 1) ? $clog2(N) : 1;

   logic [PW-1:0] ptr;
   logic [PW-1:0] ptr_nxt;
   logic [PW-1:0] sel;
   logic          hit;
   int            idx;

   // Scan from ptr upward with wrap; first asserted request wins.
   always_comb begin
      gnt     = '0;
      ptr_nxt = ptr;
      hit     = 1'b0;
      idx     = 0;
      sel     = '0;
      for (int k = 0; k < N; k++) begin
         idx = int'(ptr) + k;
         if (idx >= N) idx = idx - N;
         sel = PW'(idx);
         if (!hit && !freeze && req[sel]) begin
            hit      = 1'b1;
            gnt[sel] = 1'b1;
            ptr_nxt  = (idx == N - 1) ? '0 : PW'(idx + 1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) ptr <= '0;
      else        ptr <= ptr_nxt;
   end

endmodule

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin sharing of one regfile read/write port pair,
// read response routing, and a hardware clear sequence.
// Ports: rd_* / wr_* requester side, clr_* clear control, rf_* regfile side.
module regfile_arbiter
   import regfile_pkg::*;
#(
   parameter int NREQ     = RF_NREQ,
   parameter int WIDTH    = RF_WIDTH,
   parameter int DEPTH    = RF_DEPTH,
   parameter int ADDWIDTH = RF_ADDWIDTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic [NREQ-1:0]          rd_req,
   input  logic [NREQ*ADDWIDTH-1:0] rd_addr,
   output logic [NREQ-1:0]          rd_gnt,
   output logic [NREQ-1:0]          rd_rsp_valid,
   output logic [WIDTH-1:0]         rd_rsp_data,
   input  logic [NREQ-1:0]          wr_req,
   input  logic [NREQ*ADDWIDTH-1:0] wr_addr,
   input  logic [NREQ*WIDTH-1:0]    wr_data,
   output logic [NREQ-1:0]          wr_gnt,
   input  logic                     clr_start,
   output logic                     clr_busy,
   output logic                     clr_done,
   output logic                     rf_writeEnable,
   output logic                     rf_readEnable,
   output logic [ADDWIDTH-1:0]      rf_dest,
   output logic [ADDWIDTH-1:0]      rf_source,
   output logic [WIDTH-1:0]         rf_dataIn,
   input  logic [WIDTH-1:0]         rf_dataOut
);

   localparam logic [ADDWIDTH-1:0] LAST = ADDWIDTH'(DEPTH - 1);

   logic [0:0]          state;
   logic [ADDWIDTH-1:0] clr_cnt;
   logic [ADDWIDTH-1:0] rd_sel;
   logic [ADDWIDTH-1:0] wr_sel;
   logic [WIDTH-1:0]    wr_dsel;

   assign clr_busy = (state == ST_CLEAR);

   rr_arbiter #(.N(NREQ)) u_rd_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (rd_req),
      .freeze (1'b0),
      .gnt    (rd_gnt)
   );

   // Clearing owns the write port, so write grants stall.
   rr_arbiter #(.N(NREQ)) u_wr_arb (
      .clk    (clk),
      .reset  (reset),
      .req    (wr_req),
      .freeze (clr_busy),
      .gnt    (wr_gnt)
   );

   // Grants are one-hot, so OR-ing the selected slots is a clean mux.
   always_comb begin
      rd_sel  = '0;
      wr_sel  = '0;
      wr_dsel = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (rd_gnt[i]) rd_sel = rd_sel | rd_addr[i*ADDWIDTH +: ADDWIDTH];
         if (wr_gnt[i]) begin
            wr_sel  = wr_sel  | wr_addr[i*ADDWIDTH +: ADDWIDTH];
            wr_dsel = wr_dsel | wr_data[i*WIDTH +: WIDTH];
         end
      end
   end

   assign rf_readEnable  = |rd_gnt;
   assign rf_source      = rd_sel;
   assign rf_writeEnable = clr_busy | (|wr_gnt);
   assign rf_dest        = clr_busy ? clr_cnt : wr_sel;
   assign rf_dataIn      = clr_busy ? '0 : wr_dsel;
   assign rd_rsp_data    = rf_dataOut;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state        <= ST_IDLE;
         clr_cnt      <= '0;
         clr_done     <= 1'b0;
         rd_rsp_valid <= '0;
      end else begin
         rd_rsp_valid <= rd_gnt;
         clr_done     <= 1'b0;
         case (state)
            ST_IDLE: begin
               if (clr_start) begin
                  state   <= ST_CLEAR;
                  clr_cnt <= '0;
               end
            end
            ST_CLEAR: begin
               if (clr_cnt == LAST) begin
                  state    <= ST_IDLE;
                  clr_done <= 1'b1;
               end else begin
                  clr_cnt <= clr_cnt + ADDWIDTH'(1);
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
